// File: rtl/load_store_unit.sv
// Load/store unit: bridges the execute stage to a valid/ready data RAM, aligning store lanes,
// extending load data and reporting misalignment, illegal-funct3 and timeout faults.
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q;
   logic [2:0]       funct3_q;
   logic [31:0]      addr_q, wdata_q;
   logic             done_q, fault_q;
   logic [31:0]      rdata_q, rdata_d;
   logic             fault_d;

   logic             legal, misaligned;
   logic [1:0]       lane;
   logic [31:0]      shifted, load_data;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;

   // Legality is judged on the live request, since it decides the IDLE exit.
   always_comb begin
      if (req_write) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                             (req_funct3 == 3'b010);
      else           legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                             (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                             (req_funct3 == 3'b101);
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   assign lane    = addr_q[1:0];
   assign shifted = mem_rdata >> {lane, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      be        = 4'b1111;
      wdata_rep = 32'd0;
      if (write_q) begin
         case (funct3_q[1:0])
            2'b00: begin
               be        = 4'b0001 << lane;
               wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               be        = 4'b0011 << lane;
               wdata_rep = {2{wdata_q[15:0]}};
            end
            default: wdata_rep = wdata_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = 1'b0;
      rdata_d = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (legal && !misaligned) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_RESP;
                  fault_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               rdata_d = write_q ? 32'd0 : load_data;
            end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_d == ST_RESP);
         fault_q <= fault_d;
         rdata_q <= rdata_d;
         if (state_q == ST_IDLE && req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
      end
   end

   assign stall     = req_valid & (state_q != ST_RESP);
   assign done      = done_q;
   assign fault     = fault_q;
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == ST_REQ);
   assign mem_we    = mem_req & write_q;
   assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be    = mem_req ? be : 4'd0;
   assign mem_wdata = mem_req ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: alignment, extension, faults, timeout and reset abort.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done, fault;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.MAX_WAIT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .done       (done),
      .rdata      (rdata),
      .fault      (fault),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one access; ready_at is the REQ cycle (1-based) carrying mem_ready, 0 = never.
   task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ready_at,
                         output int cyc, output logic f, output logic [31:0] r,
                         output int req_cycles, output logic [31:0] s_addr,
                         output logic [31:0] s_wdata, output logic [3:0] s_be,
                         output logic s_we, output logic held);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      mem_rdata  = rd;
      mem_ready  = 1'b0;
      cyc        = 0;
      req_cycles = 0;
      held       = 1'b1;
      s_addr     = 32'd0;
      s_wdata    = 32'd0;
      s_be       = 4'd0;
      s_we       = 1'b0;
      while (!done && cyc < 100) begin
         if (mem_req) begin
            req_cycles++;
            if (req_cycles > 1 && (mem_addr !== s_addr || mem_be !== s_be ||
                                   mem_wdata !== s_wdata || mem_we !== s_we))
               held = 1'b0;
            s_addr  = mem_addr;
            s_wdata = mem_wdata;
            s_be    = mem_be;
            s_we    = mem_we;
            mem_ready = (req_cycles == ready_at);
         end else begin
            mem_ready = 1'b0;
         end
         step();
         cyc++;
      end
      check("done_within_bound", {31'd0, done}, 32'd1);
      f = fault;
      r = rdata;
      check("stall_low_in_resp", {31'd0, stall}, 32'd0);
      req_valid = 1'b0;
      mem_ready = 1'b0;
      step();
      check("done_single_pulse", {31'd0, done}, 32'd0);
   endtask

   int          cyc, rc;
   logic        f, we, held;
   logic [31:0] r, sa, sw;
   logic [3:0]  sb;

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'd0;
      step();
      step();
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0;

      // LW 0x08 with immediate ready.
      access(1'b0, 3'b010, 32'h08, 32'd0, 32'hDEADBEEF, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("lw_latency", cyc, 2);
      check("lw_rdata", r, 32'hDEADBEEF);
      check("lw_fault", {31'd0, f}, 32'd0);
      check("lw_addr", sa, 32'h08);
      check("lw_be", {28'd0, sb}, 32'hF);
      check("lw_we", {31'd0, we}, 32'd0);

      // Load extension with word 0x80112233.
      access(1'b0, 3'b000, 32'h0B, 32'd0, 32'h80112233, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("lb_rdata", r, 32'hFFFFFF80);
      check("lb_addr", sa, 32'h08);
      access(1'b0, 3'b100, 32'h0B, 32'd0, 32'h80112233, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("lbu_rdata", r, 32'h00000080);
      access(1'b0, 3'b001, 32'h02, 32'd0, 32'h80112233, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("lh_rdata", r, 32'hFFFF8011);
      access(1'b0, 3'b101, 32'h00, 32'd0, 32'h80112233, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("lhu_rdata", r, 32'h00002233);

      // Stores.
      access(1'b1, 3'b000, 32'h05, 32'hAB, 32'hFFFFFFFF, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("sb_we", {31'd0, we}, 32'd1);
      check("sb_addr", sa, 32'h04);
      check("sb_be", {28'd0, sb}, 32'h2);
      check("sb_wdata", sw, 32'hABABABAB);
      check("sb_rdata", r, 32'd0);
      access(1'b1, 3'b001, 32'h06, 32'h1234, 32'd0, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("sh_be", {28'd0, sb}, 32'hC);
      check("sh_wdata", sw, 32'h12341234);
      access(1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, 32'd0, 2, cyc, f, r, rc, sa, sw, sb, we, held);
      check("sw_be", {28'd0, sb}, 32'hF);
      check("sw_wdata", sw, 32'hCAFEF00D);
      check("sw_fault", {31'd0, f}, 32'd0);
      check("sw_held", {31'd0, held}, 32'd1);

      // Faults without a memory request.
      access(1'b0, 3'b010, 32'h06, 32'd0, 32'h11111111, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("mis_lw_req", rc, 0);
      check("mis_lw_latency", cyc, 1);
      check("mis_lw_fault", {31'd0, f}, 32'd1);
      check("mis_lw_rdata", r, 32'd0);
      access(1'b0, 3'b001, 32'h03, 32'd0, 32'h11111111, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("mis_lh_fault", {31'd0, f}, 32'd1);
      access(1'b0, 3'b011, 32'h00, 32'd0, 32'h11111111, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("ill_ld_req", rc, 0);
      check("ill_ld_fault", {31'd0, f}, 32'd1);
      access(1'b1, 3'b100, 32'h00, 32'd0, 32'h0, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("ill_st_fault", {31'd0, f}, 32'd1);

      // Timeout and last-cycle ready.
      access(1'b0, 3'b010, 32'h10, 32'd0, 32'h55555555, 0, cyc, f, r, rc, sa, sw, sb, we, held);
      check("to_req_cycles", rc, 16);
      check("to_fault", {31'd0, f}, 32'd1);
      check("to_rdata", r, 32'd0);
      check("to_held", {31'd0, held}, 32'd1);
      access(1'b0, 3'b010, 32'h10, 32'd0, 32'h55555555, 16, cyc, f, r, rc, sa, sw, sb, we, held);
      check("last_req_cycles", rc, 16);
      check("last_fault", {31'd0, f}, 32'd0);
      check("last_rdata", r, 32'h55555555);

      // Reset during REQ abandons the access.
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      mem_ready  = 1'b0;
      step();
      check("abort_in_req", {31'd0, mem_req}, 32'd1);
      reset     = 1'b1;
      req_valid = 1'b0;
      step();
      reset = 1'b0;
      check("abort_mem_req", {31'd0, mem_req}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      step();
      check("abort_no_late_done", {31'd0, done}, 32'd0);
      access(1'b0, 3'b010, 32'h20, 32'd0, 32'h0BADF00D, 1, cyc, f, r, rc, sa, sw, sb, we, held);
      check("post_abort_latency", cyc, 2);
      check("post_abort_rdata", r, 32'h0BADF00D);
      check("post_abort_fault", {31'd0, f}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
